// File: rtl/bcd_time_core.sv
// bcd_time_core: BCD time-keeping core (mm:ss or hh:mm:ss), count up or down,
// per-field adjust, load with clamping, lap capture and countdown expiry.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick_1hz          1-cycle count pulse (steps time by 1 s in RUN)
//   tick_adj          1-cycle adjust-rate pulse (steps selected field in adjust)
//   run_toggle        toggles RUN<->PAUSE, DONE->PAUSE
//   clear             zeroes time and lap
//   dir_down          0 = count up, 1 = count down
//   adj_en, adj_sel   adjust mode level and field select (0=ss,1=mm,2=hh)
//   load_en, load_val load packed BCD preset (clamped)
//   lap_req           capture pre-update time into lap_digits
//   digits            packed BCD time {top tens, top ones, ..., ss tens, ss ones}
//   lap_digits        captured time, lap_valid marks a capture
//   running           1 in RUN
//   expired, rollover 1-cycle pulses on countdown reaching zero / count-up wrap
//   blink_field       one-hot mask of the field under adjust
module bcd_time_core #(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned HOUR_MAX   = 23,
    parameter bit          START_RUN  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_1hz,
    input  logic                    tick_adj,
    input  logic                    run_toggle,
    input  logic                    clear,
    input  logic                    dir_down,
    input  logic                    adj_en,
    input  logic [1:0]              adj_sel,
    input  logic                    load_en,
    input  logic [8*NUM_FIELDS-1:0] load_val,
    input  logic                    lap_req,
    output logic [8*NUM_FIELDS-1:0] digits,
    output logic [8*NUM_FIELDS-1:0] lap_digits,
    output logic                    lap_valid,
    output logic                    running,
    output logic                    expired,
    output logic                    rollover,
    output logic [NUM_FIELDS-1:0]   blink_field
);

    localparam int unsigned W           = 8 * NUM_FIELDS;
    localparam int unsigned TOP_MAX     = (NUM_FIELDS == 3) ? HOUR_MAX : 59;
    localparam logic [7:0]  TOP_MAX_BCD = 8'(((TOP_MAX / 10) << 4) | (TOP_MAX % 10));
    localparam logic [7:0]  SUB_MAX_BCD = 8'h59;

    typedef enum logic [1:0] {S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          digits_q, digits_d;
    logic [W-1:0]          lap_q, lap_d;
    logic                  lap_valid_q, lap_valid_d;
    logic                  running_q;
    logic                  expired_q, expired_d;
    logic                  rollover_q, rollover_d;
    logic [NUM_FIELDS-1:0] blink_q, blink_d;
    logic                  carry;
    logic                  all_zero;

    function automatic logic [7:0] field_max(input int unsigned f);
        return (f == NUM_FIELDS - 1) ? TOP_MAX_BCD : SUB_MAX_BCD;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        t = v[7:4] + 4'd1;
        return (v[3:0] == 4'd9) ? {t, 4'd0} : {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] t;
        t = v[7:4] - 4'd1;
        return (v[3:0] == 4'd0) ? {t, 4'd9} : {v[7:4], 4'(v[3:0] - 4'd1)};
    endfunction

    // Force each digit into 0..9, then clamp the field to its maximum.
    function automatic logic [7:0] load_fix(input logic [7:0] v, input logic [7:0] mx);
        logic [7:0] f;
        f[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        f[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return (f > mx) ? mx : f;
    endfunction

    // Next-state, time update and pulse generation.
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        expired_d   = 1'b0;
        rollover_d  = 1'b0;
        blink_d     = '0;
        carry       = 1'b1;
        all_zero    = (digits_q == '0);

        if (adj_en && (32'(adj_sel) < NUM_FIELDS)) begin
            blink_d = NUM_FIELDS'(1) << adj_sel;
        end

        if (lap_req) begin
            lap_d       = digits_q;
            lap_valid_d = 1'b1;
        end

        if (clear) begin
            digits_d    = '0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
        end else if (load_en) begin
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                digits_d[8*f +: 8] = load_fix(load_val[8*f +: 8], field_max(f));
            end
        end else if (adj_en) begin
            // Adjust wraps within the selected field only; counting is frozen.
            if (tick_adj) begin
                for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                    if (32'(adj_sel) == f) begin
                        digits_d[8*f +: 8] = (digits_q[8*f +: 8] == field_max(f)) ?
                                             8'h00 : bcd_inc(digits_q[8*f +: 8]);
                    end
                end
            end
        end else if ((state_q == S_RUN) && tick_1hz) begin
            if (!dir_down) begin
                // Ripple carry; a carry out of the top field leaves all fields at zero.
                for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                    if (carry) begin
                        if (digits_q[8*f +: 8] == field_max(f)) begin
                            digits_d[8*f +: 8] = 8'h00;
                        end else begin
                            digits_d[8*f +: 8] = bcd_inc(digits_q[8*f +: 8]);
                            carry              = 1'b0;
                        end
                    end
                end
                rollover_d = carry;
            end else begin
                if (!all_zero) begin
                    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                        if (carry) begin
                            if (digits_q[8*f +: 8] == 8'h00) begin
                                digits_d[8*f +: 8] = field_max(f);
                            end else begin
                                digits_d[8*f +: 8] = bcd_dec(digits_q[8*f +: 8]);
                                carry              = 1'b0;
                            end
                        end
                    end
                end
                // Expire when the countdown lands on zero or is ticked while at zero.
                expired_d = (digits_d == '0);
            end
        end

        if (run_toggle) begin
            state_d = (state_q == S_PAUSE) ? S_RUN : S_PAUSE;
        end else if ((clear || load_en) && (state_q == S_DONE)) begin
            state_d = S_PAUSE;
        end
        if (expired_d) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= START_RUN ? S_RUN : S_PAUSE;
            running_q   <= START_RUN;
            digits_q    <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            expired_q   <= 1'b0;
            rollover_q  <= 1'b0;
            blink_q     <= '0;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d == S_RUN);
            digits_q    <= digits_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            expired_q   <= expired_d;
            rollover_q  <= rollover_d;
            blink_q     <= blink_d;
        end
    end

    assign digits      = digits_q;
    assign lap_digits  = lap_q;
    assign lap_valid   = lap_valid_q;
    assign running     = running_q;
    assign expired     = expired_q;
    assign rollover    = rollover_q;
    assign blink_field = blink_q;

endmodule

// File: tb/tb_bcd_time_core.sv
// Bench for bcd_time_core: a 2-field instance (START_RUN=1) and a 3-field
// instance (HOUR_MAX=23, START_RUN=0) checked every cycle against a model that
// keeps time as a plain count of seconds, plus hand-computed literal checks.
module tb_bcd_time_core;

    typedef struct packed {
        logic        tick;
        logic        tadj;
        logic        tog;
        logic        clr;
        logic        dn;
        logic        adj;
        logic [1:0]  sel;
        logic        ld;
        logic [23:0] lv;
        logic        lap;
    } in_t;

    typedef struct {
        int t;
        int st;     // 0 run, 1 pause, 2 done
        int lap;
        bit lapv;
        bit ex;
        bit ro;
        int blink;
    } m_t;

    localparam int ST_RUN = 0, ST_PAUSE = 1, ST_DONE = 2;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    in_t  ia, ib;
    m_t   ma, mb;
    int   checks = 0;
    int   failures = 0;
    int   rol_cnt_a = 0;

    logic [15:0] a_dig, a_lap;
    logic        a_lapv, a_run, a_ex, a_ro;
    logic [1:0]  a_bl;
    logic [23:0] b_dig, b_lap;
    logic        b_lapv, b_run, b_ex, b_ro;
    logic [2:0]  b_bl;

    always #5 clk = ~clk;

    bcd_time_core #(.NUM_FIELDS(2), .HOUR_MAX(23), .START_RUN(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .tick_1hz(ia.tick), .tick_adj(ia.tadj),
        .run_toggle(ia.tog), .clear(ia.clr), .dir_down(ia.dn), .adj_en(ia.adj),
        .adj_sel(ia.sel), .load_en(ia.ld), .load_val(ia.lv[15:0]), .lap_req(ia.lap),
        .digits(a_dig), .lap_digits(a_lap), .lap_valid(a_lapv), .running(a_run),
        .expired(a_ex), .rollover(a_ro), .blink_field(a_bl)
    );

    bcd_time_core #(.NUM_FIELDS(3), .HOUR_MAX(23), .START_RUN(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .tick_1hz(ib.tick), .tick_adj(ib.tadj),
        .run_toggle(ib.tog), .clear(ib.clr), .dir_down(ib.dn), .adj_en(ib.adj),
        .adj_sel(ib.sel), .load_en(ib.ld), .load_val(ib.lv), .lap_req(ib.lap),
        .digits(b_dig), .lap_digits(b_lap), .lap_valid(b_lapv), .running(b_run),
        .expired(b_ex), .rollover(b_ro), .blink_field(b_bl)
    );

    function automatic int fmax(int nf, int hm, int f);
        return (nf == 3 && f == 2) ? hm : 59;
    endfunction

    function automatic int unit_s(int f);
        return (f == 0) ? 1 : ((f == 1) ? 60 : 3600);
    endfunction

    function automatic int fld(int t, int nf, int f);
        if (f == 0) return t % 60;
        if (f == 1) return (nf == 2) ? t / 60 : (t / 60) % 60;
        return t / 3600;
    endfunction

    function automatic logic [23:0] to_bcd(int t, int nf);
        logic [23:0] r;
        int v;
        r = '0;
        for (int f = 0; f < nf; f++) begin
            v = fld(t, nf, f);
            r[8*f +: 8] = {4'(v / 10), 4'(v % 10)};
        end
        return r;
    endfunction

    function automatic m_t reset_m(bit start_run);
        m_t m;
        m.t = 0; m.st = start_run ? ST_RUN : ST_PAUSE; m.lap = 0;
        m.lapv = 0; m.ex = 0; m.ro = 0; m.blink = 0;
        return m;
    endfunction

    function automatic m_t step(m_t m, in_t i, int nf, int hm);
        m_t n;
        int modv, v, tens, ones, sel, u;
        n = m;
        modv = (nf == 2) ? 3600 : (hm + 1) * 3600;
        sel = int'(i.sel);
        n.ex = 0;
        n.ro = 0;
        n.blink = (i.adj && sel < nf) ? (1 << sel) : 0;
        if (i.lap) begin
            n.lap = m.t;
            n.lapv = 1;
        end
        if (i.clr) begin
            n.t = 0; n.lap = 0; n.lapv = 0;
        end else if (i.ld) begin
            n.t = 0;
            for (int f = 0; f < nf; f++) begin
                tens = int'(i.lv[8*f+4 +: 4]);
                ones = int'(i.lv[8*f +: 4]);
                if (tens > 9) tens = 9;
                if (ones > 9) ones = 9;
                v = tens * 10 + ones;
                if (v > fmax(nf, hm, f)) v = fmax(nf, hm, f);
                n.t += v * unit_s(f);
            end
        end else if (i.adj) begin
            if (i.tadj && sel < nf) begin
                v = fld(m.t, nf, sel);
                u = unit_s(sel);
                n.t = m.t - v * u + ((v == fmax(nf, hm, sel)) ? 0 : v + 1) * u;
            end
        end else if (m.st == ST_RUN && i.tick) begin
            if (i.dn) begin
                if (m.t > 0) n.t = m.t - 1;
                n.ex = (n.t == 0);
            end else begin
                n.t = (m.t + 1) % modv;
                n.ro = (n.t == 0);
            end
        end
        if (i.tog) n.st = (m.st == ST_PAUSE) ? ST_RUN : ST_PAUSE;
        else if ((i.clr || i.ld) && m.st == ST_DONE) n.st = ST_PAUSE;
        if (n.ex) n.st = ST_DONE;
        return n;
    endfunction

    always @(posedge clk or posedge rst_a)
        if (rst_a) ma <= reset_m(1'b1);
        else       ma <= step(ma, ia, 2, 23);

    always @(posedge clk or posedge rst_b)
        if (rst_b) mb <= reset_m(1'b0);
        else       mb <= step(mb, ib, 3, 23);

    task automatic chk(string nm, logic [23:0] got, logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("A.digits",  24'(a_dig),  to_bcd(ma.t, 2));
        chk("A.lap",     24'(a_lap),  to_bcd(ma.lap, 2));
        chk("A.lapv",    24'(a_lapv), 24'(ma.lapv));
        chk("A.running", 24'(a_run),  24'(ma.st == ST_RUN));
        chk("A.expired", 24'(a_ex),   24'(ma.ex));
        chk("A.rollover",24'(a_ro),   24'(ma.ro));
        chk("A.blink",   24'(a_bl),   24'(ma.blink));
        chk("B.digits",  b_dig,       to_bcd(mb.t, 3));
        chk("B.lap",     b_lap,       to_bcd(mb.lap, 3));
        chk("B.lapv",    24'(b_lapv), 24'(mb.lapv));
        chk("B.running", 24'(b_run),  24'(mb.st == ST_RUN));
        chk("B.expired", 24'(b_ex),   24'(mb.ex));
        chk("B.rollover",24'(b_ro),   24'(mb.ro));
        chk("B.blink",   24'(b_bl),   24'(mb.blink));
        if (a_ro) rol_cnt_a++;
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ia = '0;
        ib = '0;
        cyc(2);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("L.A_reset_digits", 24'(a_dig), 24'h0);
        chk("L.A_reset_running", 24'(a_run), 24'h1);
        chk("L.B_reset_running", 24'(b_run), 24'h0);

        // 60 ticks -> 01:00, full hour -> wrap with one rollover
        ia.tick = 1'b1;
        cyc(60);
        chk("L.A_60s", 24'(a_dig), 24'h0100);
        cyc(3540);
        chk("L.A_3600s", 24'(a_dig), 24'h0000);
        chk("L.A_rollover", 24'(a_ro), 24'h1);
        ia.tick = 1'b0;
        cyc(2);
        chk("L.A_rollover_count", 24'(rol_cnt_a), 24'd1);

        // Countdown from 00:03
        ia.dn = 1'b1; ia.ld = 1'b1; ia.lv = 24'h000003;
        cyc(1);
        ia.ld = 1'b0;
        chk("L.A_load3", 24'(a_dig), 24'h0003);
        ia.tick = 1'b1;
        cyc(2);
        chk("L.A_down1", 24'(a_dig), 24'h0001);
        chk("L.A_not_expired", 24'(a_ex), 24'h0);
        cyc(1);
        chk("L.A_down0", 24'(a_dig), 24'h0000);
        chk("L.A_expired", 24'(a_ex), 24'h1);
        chk("L.A_done_running", 24'(a_run), 24'h0);
        cyc(3);
        chk("L.A_done_hold", 24'(a_dig), 24'h0000);
        chk("L.A_done_no_pulse", 24'(a_ex), 24'h0);
        ia.tick = 1'b0; ia.tog = 1'b1;
        cyc(1);
        chk("L.A_done_to_pause", 24'(a_run), 24'h0);
        cyc(1);
        chk("L.A_pause_to_run", 24'(a_run), 24'h1);
        ia.tog = 1'b0;

        // Pause at 00:12, adjust seconds by 50 with wrap
        ia.dn = 1'b0; ia.ld = 1'b1; ia.lv = 24'h000012;
        cyc(1);
        ia.ld = 1'b0; ia.tog = 1'b1;
        cyc(1);
        ia.tog = 1'b0;
        chk("L.A_paused", 24'(a_run), 24'h0);
        ia.adj = 1'b1; ia.sel = 2'd0;
        cyc(1);
        chk("L.A_blink", 24'(a_bl), 24'h1);
        ia.tadj = 1'b1;
        cyc(50);
        ia.tadj = 1'b0;
        chk("L.A_adj50", 24'(a_dig), 24'h0002);
        ia.tog = 1'b1;
        cyc(1);
        chk("L.A_adj_tog_run", 24'(a_run), 24'h1);
        cyc(1);
        ia.tog = 1'b0; ia.adj = 1'b0; ia.tick = 1'b1;
        cyc(40);
        ia.tick = 1'b0;
        chk("L.A_still_paused", 24'(a_dig), 24'h0002);
        chk("L.A_blink_off", 24'(a_bl), 24'h0);

        // Same-cycle tick + lap, then clear + load
        ia.tog = 1'b1; ia.ld = 1'b1; ia.lv = 24'h000059;
        cyc(1);
        ia.tog = 1'b0; ia.ld = 1'b0; ia.tick = 1'b1; ia.lap = 1'b1;
        cyc(1);
        ia.tick = 1'b0; ia.lap = 1'b0;
        chk("L.A_lap", 24'(a_lap), 24'h0059);
        chk("L.A_lap_step", 24'(a_dig), 24'h0100);
        chk("L.A_lapv", 24'(a_lapv), 24'h1);
        ia.clr = 1'b1; ia.ld = 1'b1; ia.lv = 24'h000030;
        cyc(1);
        ia.clr = 1'b0; ia.ld = 1'b0;
        chk("L.A_clear_digits", 24'(a_dig), 24'h0);
        chk("L.A_clear_lapv", 24'(a_lapv), 24'h0);

        // Three fields: wrap at 23:59:59, clamp on load
        ib.ld = 1'b1; ib.lv = 24'h235959;
        cyc(1);
        ib.ld = 1'b0; ib.tog = 1'b1;
        cyc(1);
        ib.tog = 1'b0; ib.tick = 1'b1;
        cyc(1);
        ib.tick = 1'b0;
        chk("L.B_wrap", b_dig, 24'h000000);
        chk("L.B_rollover", 24'(b_ro), 24'h1);
        ib.ld = 1'b1; ib.lv = 24'h995999;
        cyc(1);
        chk("L.B_clamp", b_dig, 24'h235959);
        ib.lv = 24'h0A5F3C;
        cyc(1);
        chk("L.B_digit_fix", b_dig, 24'h095939);
        ib.lv = 24'h230000; ib.adj = 1'b1; ib.sel = 2'd2;
        cyc(1);
        ib.ld = 1'b0; ib.tadj = 1'b1;
        cyc(1);
        chk("L.B_hour_wrap", b_dig, 24'h000000);
        ib.sel = 2'd3;
        cyc(2);
        ib.tadj = 1'b0;
        chk("L.B_sel_ignored", b_dig, 24'h000000);
        chk("L.B_blink_none", 24'(b_bl), 24'h0);

        // Async reset in the middle of an adjust
        ib.ld = 1'b1; ib.lv = 24'h120000; ib.sel = 2'd1;
        cyc(1);
        ib.ld = 1'b0; ib.lap = 1'b1;
        cyc(1);
        ib.lap = 1'b0;
        chk("L.B_lap_pre_rst", 24'(b_lapv), 24'h1);
        @(negedge clk);
        #2;
        rst_b = 1'b1;
        #1;
        chk("L.B_rst_digits", b_dig, 24'h0);
        chk("L.B_rst_running", 24'(b_run), 24'h0);
        chk("L.B_rst_blink", 24'(b_bl), 24'h0);
        chk("L.B_rst_lapv", 24'(b_lapv), 24'h0);
        ib.adj = 1'b0;
        cyc(1);
        rst_b = 1'b0;
        ib.tick = 1'b1;
        cyc(1);
        ib.tick = 1'b0;
        chk("L.B_after_rst_paused", b_dig, 24'h0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
